// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl: 8-bit LFSR sequencer (seed load, single-step, prescaled free-run), lockup detect, hex display.
// Optional: define LFSR_CTRL_GUARD_EN to substitute 8'h01 for a zero seed, making the lockup state unreachable.
module lfsr_ctrl #(
   parameter int unsigned DIV_W   = 24,
   parameter int unsigned DIV_MAX = 9_999_999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  seed_i,
   input  logic        load_i,
   input  logic        step_i,
   input  logic        run_i,
   output logic [7:0]  lfsr_o,
   output logic        zero_o,
   output logic [1:0]  state_o,
   output logic [15:0] step_cnt_o,
   output logic [7:0]  seg0,
   output logic [7:0]  seg1
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LOCK = 2'd2} state_t;

   localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(DIV_MAX);

   state_t           state, state_nxt;
   logic             load_prev, step_prev;
   logic             load_edge, step_edge;
   logic             in_idle, in_run, tick, do_shift;
   logic [DIV_W-1:0] presc;
   logic [7:0]       lfsr, seed_eff;
   logic [15:0]      step_cnt;
   logic             fb;

   // Active-low a..g on bits[7:1], decimal point (bit0) always dark.
   function automatic logic [7:0] hex_seg(input logic [3:0] d);
      case (d)
         4'h0: return 8'b0000_0011;
         4'h1: return 8'b1001_1111;
         4'h2: return 8'b0010_0101;
         4'h3: return 8'b0000_1101;
         4'h4: return 8'b1001_1001;
         4'h5: return 8'b0100_1001;
         4'h6: return 8'b0100_0001;
         4'h7: return 8'b0001_1111;
         4'h8: return 8'b0000_0001;
         4'h9: return 8'b0000_1001;
         4'hA: return 8'b0001_0001;
         4'hB: return 8'b1100_0001;
         4'hC: return 8'b0110_0011;
         4'hD: return 8'b1000_0101;
         4'hE: return 8'b0110_0001;
         default: return 8'b0111_0001;
      endcase
   endfunction

   // Edge history keeps sampling through reset so a level held across reset is not an edge.
   always_ff @(posedge clk) begin
      load_prev <= load_i;
      step_prev <= step_i;
   end

   assign load_edge = load_i & ~load_prev;
   assign step_edge = step_i & ~step_prev;
   assign fb        = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4];

`ifdef LFSR_CTRL_GUARD_EN
   assign seed_eff = (seed_i == 8'h00) ? 8'h01 : seed_i;
   assign zero_o   = 1'b0;
`else
   assign seed_eff = seed_i;
   assign zero_o   = (lfsr == 8'h00);
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
`ifdef LFSR_CTRL_GUARD_EN
      if (run_i) state_nxt = RUN;
`else
      if (lfsr == 8'h00) state_nxt = LOCK;
      else if (run_i)    state_nxt = RUN;
`endif
   end

   always_comb begin
      in_idle  = (state == IDLE);
      in_run   = (state == RUN);
      tick     = in_run && (presc == PRESC_MAX);
      do_shift = !load_edge && ((step_edge && in_idle) || tick);
   end

   // A load wins over step and tick in the same cycle; the losers are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr     <= 8'h01;
         step_cnt <= '0;
         presc    <= '0;
      end else begin
         if (load_edge) begin
            lfsr     <= seed_eff;
            step_cnt <= '0;
         end else if (do_shift) begin
            lfsr     <= {fb, lfsr[7:1]};
            step_cnt <= step_cnt + 16'd1;
         end
         if (!in_run || load_edge || tick) presc <= '0;
         else                              presc <= presc + DIV_W'(1);
      end
   end

   assign lfsr_o     = lfsr;
   assign state_o    = state;
   assign step_cnt_o = step_cnt;
   assign seg0       = hex_seg(lfsr[3:0]);
   assign seg1       = hex_seg(lfsr[7:4]);

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Scoreboard bench for lfsr_ctrl: two instances (DIV_MAX=3 and DIV_MAX=0) on shared inputs,
// each checked every cycle against a behavioural model of the sequencing rules.
module tb_lfsr_ctrl;

   logic        clk = 1'b0;
   logic        rst, load_i, step_i, run_i;
   logic [7:0]  seed_i;

   logic [7:0]  lfsr_a, seg0_a, seg1_a, lfsr_b, seg0_b, seg1_b;
   logic        zero_a, zero_b;
   logic [1:0]  state_a, state_b;
   logic [15:0] cnt_a, cnt_b;

`ifdef LFSR_CTRL_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   typedef struct {
      logic [7:0]  val;
      logic [15:0] shifts;
      int          mode;      // 0 idle, 1 run, 2 lock
      int          run_age;   // cycles since the run period last restarted
      bit          load_seen;
      bit          step_seen;
   } mdl_t;

   typedef struct {
      logic [7:0]  lfsr;
      logic        zero;
      logic [1:0]  st;
      logic [15:0] cnt;
      logic [7:0]  s0;
      logic [7:0]  s1;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   mdl_t ma, mb;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   lfsr_ctrl #(.DIV_W(24), .DIV_MAX(3)) dut_a (
      .clk(clk), .rst(rst), .seed_i(seed_i), .load_i(load_i), .step_i(step_i), .run_i(run_i),
      .lfsr_o(lfsr_a), .zero_o(zero_a), .state_o(state_a), .step_cnt_o(cnt_a),
      .seg0(seg0_a), .seg1(seg1_a)
   );

   lfsr_ctrl #(.DIV_W(24), .DIV_MAX(0)) dut_b (
      .clk(clk), .rst(rst), .seed_i(seed_i), .load_i(load_i), .step_i(step_i), .run_i(run_i),
      .lfsr_o(lfsr_b), .zero_o(zero_b), .state_o(state_b), .step_cnt_o(cnt_b),
      .seg0(seg0_b), .seg1(seg1_b)
   );

   function automatic string seg_lit(input logic [3:0] d);
      case (d)
         4'h0: return "abcdef";
         4'h1: return "bc";
         4'h2: return "abdeg";
         4'h3: return "abcdg";
         4'h4: return "bcfg";
         4'h5: return "acdfg";
         4'h6: return "acdefg";
         4'h7: return "abc";
         4'h8: return "abcdefg";
         4'h9: return "abcdfg";
         4'hA: return "abcefg";
         4'hB: return "cdefg";
         4'hC: return "adef";
         4'hD: return "bcdeg";
         4'hE: return "adefg";
         default: return "aefg";
      endcase
   endfunction

   function automatic logic [7:0] seg_of(input logic [3:0] d);
      string      s;
      logic [7:0] r;
      int         k;
      s = seg_lit(d);
      r = 8'hFF;
      for (int i = 0; i < s.len(); i++) begin
         k = int'(s[i]) - 97;
         r[7-k] = 1'b0;
      end
      return r;
   endfunction

   function automatic logic [7:0] shifted(input logic [7:0] v);
      return {^(v & 8'h1D), v[7:1]};
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input int dmax);
      mdl_t n;
      bit   le, se, tick;
      n = m;
      if (rst) begin
         n.val = 8'h01; n.shifts = 16'd0; n.mode = 0; n.run_age = 0;
      end else begin
         le   = load_i && !m.load_seen;
         se   = step_i && !m.step_seen;
         tick = (m.mode == 1) && (m.run_age == dmax);
         n.mode = (m.val == 8'h00) ? 2 : (run_i ? 1 : 0);
         if (le) begin
            n.val    = (GUARD && seed_i == 8'h00) ? 8'h01 : seed_i;
            n.shifts = 16'd0;
         end else if ((se && m.mode == 0) || tick) begin
            n.val    = shifted(m.val);
            n.shifts = m.shifts + 16'd1;
         end
         n.run_age = (m.mode != 1 || le || tick) ? 0 : m.run_age + 1;
      end
      n.load_seen = load_i;
      n.step_seen = step_i;
      return n;
   endfunction

   function automatic exp_t mk_exp(input mdl_t m);
      exp_t e;
      e.lfsr = m.val;
      e.zero = (m.val == 8'h00);
      e.st   = 2'(m.mode);
      e.cnt  = m.shifts;
      e.s0   = seg_of(m.val[3:0]);
      e.s1   = seg_of(m.val[7:4]);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic cmp_out(input string tag, input exp_t e, input logic [7:0] l, input logic z,
                          input logic [1:0] s, input logic [15:0] c,
                          input logic [7:0] s0, input logic [7:0] s1);
      chk({tag, "_lfsr"}, l, e.lfsr);
      chk({tag, "_zero"}, z, e.zero);
      chk({tag, "_state"}, s, e.st);
      chk({tag, "_cnt"}, c, e.cnt);
      chk({tag, "_seg0"}, s0, e.s0);
      chk({tag, "_seg1"}, s1, e.s1);
   endtask

   // Monitor: one expected snapshot per clock for each instance.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (qa.size() > 0) cmp_out("a", qa.pop_front(), lfsr_a, zero_a, state_a, cnt_a, seg0_a, seg1_a);
         if (qb.size() > 0) cmp_out("b", qb.pop_front(), lfsr_b, zero_b, state_b, cnt_b, seg0_b, seg1_b);
      end
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         ma = mstep(ma, 3);
         mb = mstep(mb, 0);
         qa.push_back(mk_exp(ma));
         qb.push_back(mk_exp(mb));
         @(negedge clk);
      end
   endtask

   task automatic do_load(input logic [7:0] s);
      seed_i = s; load_i = 1'b1; cyc(1);
      load_i = 1'b0; cyc(1);
   endtask

   initial begin
      logic [7:0] step_v [6];
      int         n, w;
      step_v = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88, 8'hC4};
      rst = 1'b1; seed_i = 8'h00; load_i = 1'b0; step_i = 1'b0; run_i = 1'b0;
      cyc(2);
      chk("rst_lfsr", lfsr_a, 8'h01);
      chk("rst_state", state_a, 2'd0);
      chk("rst_cnt", cnt_a, 16'd0);
      chk("rst_zero", zero_a, 1'b0);
      chk("rst_seg0", seg0_a, 8'b1001_1111);
      chk("rst_seg1", seg1_a, 8'b0000_0011);

      // Single steps in IDLE
      rst = 1'b0;
      do_load(8'h01);
      for (int k = 0; k < 6; k++) begin
         step_i = 1'b1; cyc(1);
         step_i = 1'b0; cyc(1);
         chk("step_lfsr", lfsr_a, step_v[k]);
         if (k == 4) begin
            chk("seg0_88", seg0_a, 8'b0000_0001);
            chk("seg1_88", seg1_a, 8'b0000_0001);
         end
      end
      chk("step_cnt6", cnt_a, 16'd6);

      // Load and step edges together: load wins
      seed_i = 8'h5A; load_i = 1'b1; step_i = 1'b1; cyc(1);
      chk("ldstep_lfsr", lfsr_a, 8'h5A);
      chk("ldstep_cnt", cnt_a, 16'd0);
      load_i = 1'b0; step_i = 1'b0; cyc(1);
      chk("ldstep_hold", lfsr_a, 8'h5A);

      // Run mode with DIV_MAX=3, step edges ignored
      do_load(8'h01);
      run_i = 1'b1;
      n = 0;
      while (state_a != 2'd1 && n < 10) begin cyc(1); n++; end
      chk("run_enter", state_a, 2'd1);
      n = 0;
      while (lfsr_a == 8'h01 && n < 20) begin step_i = ~step_i; cyc(1); n++; end
      chk("run_lat1", n, 4);
      chk("run_val1", lfsr_a, 8'h80);
      n = 0;
      while (lfsr_a == 8'h80 && n < 20) begin step_i = ~step_i; cyc(1); n++; end
      chk("run_lat2", n, 4);
      chk("run_val2", lfsr_a, 8'h40);
      step_i = 1'b0; run_i = 1'b0; cyc(2);

      // Zero seed
      seed_i = 8'h00; load_i = 1'b1; cyc(1);
      load_i = 1'b0;
`ifdef LFSR_CTRL_GUARD_EN
      chk("guard_lfsr", lfsr_a, 8'h01);
      chk("guard_zero", zero_a, 1'b0);
      cyc(1);
      chk("guard_nolock", (state_a == 2'd2), 1'b0);
`else
      chk("lock_zero", zero_a, 1'b1);
      chk("lock_lag", state_a, 2'd0);
      cyc(1);
      chk("lock_state", state_a, 2'd2);
      for (int k = 0; k < 3; k++) begin step_i = 1'b1; cyc(1); step_i = 1'b0; cyc(1); end
      run_i = 1'b1; cyc(8);
      chk("lock_hold", lfsr_a, 8'h00);
      chk("lock_stay", state_a, 2'd2);
      do_load(8'h01);
      chk("lock_exit", state_a, 2'd1);
`endif
      run_i = 1'b0; cyc(2);

      // Counter wrap on the DIV_MAX=0 instance, then reset mid-run
      do_load(8'h01);
      run_i = 1'b1; cyc(1);
      chk("wrap_run", state_b, 2'd1);
      chk("wrap_start", cnt_b, 16'd0);
      cyc(65535);
      chk("wrap_ffff", cnt_b, 16'hFFFF);
      cyc(1);
      chk("wrap_zero", cnt_b, 16'h0000);
      rst = 1'b1; cyc(1);
      chk("midrst_lfsr", lfsr_b, 8'h01);
      chk("midrst_state", state_b, 2'd0);
      chk("midrst_cnt", cnt_b, 16'd0);
      rst = 1'b0; cyc(1);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         rst    = ($urandom_range(0, 99) == 0);
         load_i = ($urandom_range(0, 5) == 0);
         step_i = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) run_i = ~run_i;
         seed_i = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         cyc(1);
      end
      rst = 1'b0; load_i = 1'b0; step_i = 1'b0; run_i = 1'b0;
      cyc(2);

      w = 0;
      while ((qa.size() != 0 || qb.size() != 0) && w < 10) begin @(negedge clk); w++; end
      chk("drain", qa.size() + qb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lfsr_ctrl.md
# lfsr_ctrl

Sequencing controller for the board-level 8-bit LFSR demo. Owns the LFSR register and decides when it loads a seed, single-steps, or free-runs from a prescaled tick. It also tracks how many shifts have occurred, detects the all-zero lockup state, and drives the two active-low seven-segment digits with the current value in hex. It sits between the synchronized switch/button inputs and the board outputs (LEDs, seg0/seg1).

## Interface
- `DIV_W`, 24: prescaler counter width.
- `DIV_MAX`, 9_999_999: run-mode tick period minus one, in clk cycles. Range 0..2^DIV_W-1; 0 means a tick every cycle.
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `seed_i`  in  8  seed value, sampled on a load edge.
- `load_i`  in  1  level; a rising edge requests a seed load.
- `step_i`  in  1  level; a rising edge requests one shift, honoured only in IDLE.
- `run_i`  in  1  level; 1 selects free-run.
- `lfsr_o`  out  8  current LFSR value (register).
- `zero_o`  out  1  combinational, lfsr_o == 8'h00.
- `state_o`  out  2  FSM state: IDLE=0, RUN=1, LOCK=2.
- `step_cnt_o`  out  16  shifts since the last load.
- `seg0`  out  8  low-nibble digit, active-low, bits[7:1]=a..g, bit0=dp.
- `seg1`  out  8  high-nibble digit, same encoding.
- Input levels arrive already synchronized to clk.

## Operation
- Shift: `lfsr <= {fb, lfsr[7:1]}`, with `fb = lfsr[0]^lfsr[2]^lfsr[3]^lfsr[4]`. fb is computed from the current value; there is no delayed feedback register.
- Edge detect: `load_prev` and `step_prev` register their inputs every cycle, including while rst=1. An input held high across reset therefore produces no edge.
- Per-cycle priority, highest first:
  1. Load edge: lfsr <= seed_i, step_cnt <= 0, prescaler <= 0.
  2. Step edge while state==IDLE: one shift, step_cnt+1.
  3. Tick while state==RUN: one shift, step_cnt+1.
- A lower-priority event that loses in the same cycle is dropped, not queued.
- Step edges in RUN or LOCK are ignored.
- Prescaler: counts only in RUN. At DIV_MAX it asserts an internal tick and returns to 0. It is held at 0 in IDLE and LOCK.
- FSM next state is evaluated every cycle from the registered lfsr:
  - lfsr==0 -> LOCK;
  - else run_i -> RUN;
  - else -> IDLE.
- LOCK can only be left by loading a nonzero seed.
- step_cnt wraps from 16'hFFFF to 16'h0000 with no flag.
- Seven-segment decode is combinational from lfsr_o, hex 0-F, active-low, dp always off (bit0=1). Examples: 0 -> 8'b00000011, 1 -> 8'b10011111, 8 -> 8'b00000001, A -> 8'b00010001.

## Timing
- Reset values: lfsr_o=8'h01, step_cnt_o=0, state_o=IDLE, prescaler=0. This gives zero_o=0, seg0=8'b10011111 (1), seg1=8'b00000011 (0).
- Load/step latency: the edge is sampled at clock n (input=1, prev=0). lfsr_o and step_cnt_o update at clock n, visible from n+1.
- state_o lags lfsr_o by one cycle. Example: loading 0 changes lfsr_o at clock n and state_o goes to LOCK at n+1.
- Run: the first shift occurs DIV_MAX+1 cycles after state_o becomes RUN, then one every DIV_MAX+1 cycles.
- Dropping run_i: state_o leaves RUN one cycle later. A tick on that same edge is still applied.
- Load during RUN: the prescaler restarts, so the next shift is DIV_MAX+1 cycles after the load.
- rst asserted mid-run: all registers take their reset values on that edge; no shift occurs on it.

## Configuration
- `LFSR_CTRL_GUARD_EN` defined:
  - a load of seed 8'h00 loads 8'h01 instead;
  - LOCK is unreachable and zero_o stays 0.
- Not defined: seed 0 is loaded as-is. The LFSR holds at 0 (0 is a fixed point), zero_o=1, and state_o=LOCK until a nonzero load.

## Test plan
- Reset, load 8'h01, give four step edges in IDLE -> lfsr_o 80, 40, 20, 10, then a fifth step -> 88 and a sixth -> C4. step_cnt_o=6. With lfsr_o=88, seg0=seg1=8'b00000001.
- DIV_MAX=3, seed 8'h01, run_i=1 -> lfsr_o=80 exactly 4 cycles after state_o=RUN, then 40 four cycles later. Step edges in between have no effect.
- Load and step edges on the same cycle in IDLE, seed 8'h5A -> lfsr_o=5A, step_cnt_o=0, no shift.
- Guard undefined, load 8'h00 -> zero_o=1 next cycle, state_o=LOCK the cycle after. Steps and run_i=1 leave lfsr_o=00. Loading 8'h01 returns to IDLE (or RUN if run_i=1).
- Guard defined, load 8'h00 -> lfsr_o=01, zero_o=0, state_o never LOCK.
- DIV_MAX=0, run for 65536 cycles after state_o=RUN -> step_cnt_o wraps to 0. Asserting rst mid-run -> lfsr_o=01, state_o=IDLE, step_cnt_o=0 on the next cycle.
